// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   - N / REGW       : operand width and register index width
//   - alu_op_t       : 4-bit ALU select encoding
//   - issue_entry_t  : one buffered decoded operation
//   - occ_state_t    : occupancy of the issue stage (EMPTY / ONE / TWO)
//   - snoop_entry()  : refresh an entry's operands from a writeback
package alu_pkg;

  localparam int N    = 32;
  localparam int REGW = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_MUL = 4'b0100,
    ALU_DIV = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_NOT = 4'b1000
  } alu_op_t;

  typedef struct packed {
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic            b_imm;
    alu_op_t         s;
    logic            sign;
    logic [REGW-1:0] rd;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  // Replace operands whose source register is being written this cycle.
  // Register 0 is hard-wired and never refreshed; immediates are never refreshed.
  function automatic issue_entry_t snoop_entry(
    input issue_entry_t    e,
    input logic            wb_en,
    input logic [REGW-1:0] wb_idx,
    input logic [N-1:0]    wb_data
  );
    issue_entry_t r;
    r = e;
    if (wb_en && (wb_idx != '0)) begin
      if (e.rs == wb_idx)                r.a = wb_data;
      if ((e.rt == wb_idx) && !e.b_imm)  r.b = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_entry.sv
// alu_issue_entry: one storage entry of the issue stage.
// Ports:
//   clk, rst_n   : clock, async active-low reset (entry cleared to zero)
//   clear        : synchronous clear (flush), highest priority
//   load         : capture load_data this edge
//   load_data    : entry to capture (new op or the skid entry being promoted)
//   live         : entry currently holds a valid op and must be snooped
//   wb_en/idx/data : register-file writeback port being snooped
//   q            : stored entry
module alu_issue_entry
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  issue_entry_t    load_data,
  input  logic            live,
  input  logic            wb_en,
  input  logic [REGW-1:0] wb_idx,
  input  logic [N-1:0]    wb_data,
  output issue_entry_t    q
);

  issue_entry_t entry_q;
  issue_entry_t entry_d;
  issue_entry_t base;

  // The snoop is applied after the load mux, so a loaded entry sees the
  // same-cycle writeback (capture bypass) exactly like a resident one.
  always_comb begin
    base    = load ? load_data : entry_q;
    entry_d = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (load || live) begin
      entry_d = snoop_entry(base, wb_en, wb_idx, wb_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode -> ALU pipeline register with a 2-entry skid buffer
// and register-file writeback snooping of buffered operands.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid does not depend on ready, and once out_valid is raised the
// presented op stays put (apart from snooped operand refreshes) until it fires.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   flush                 : drop every buffered op (and any op offered this cycle)
//   in_valid / in_ready   : decode-side handshake (in_ready is registered)
//   in_a, in_b, in_rs, in_rt, in_b_imm, in_s, in_sign, in_rd : decoded op
//   wb_en, wb_idx, wb_data: register-file writeback being snooped
//   out_valid / out_ready : ALU-side handshake
//   out_a, out_b, out_s, out_sign, out_rd : op presented to the ALU
//   dbg_state             : occupancy state (EMPTY/ONE/TWO) for observation
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [REGW-1:0] in_rs,
  input  logic [REGW-1:0] in_rt,
  input  logic            in_b_imm,
  input  logic [3:0]      in_s,
  input  logic            in_sign,
  input  logic [REGW-1:0] in_rd,
  input  logic            wb_en,
  input  logic [REGW-1:0] wb_idx,
  input  logic [N-1:0]    wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_a,
  output logic [N-1:0]    out_b,
  output logic [3:0]      out_s,
  output logic            out_sign,
  output logic [REGW-1:0] out_rd,
  output logic [1:0]      dbg_state
);

  occ_state_t   state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;

  logic         accept;
  logic         fire;
  logic         main_load;
  logic         skid_load;
  logic         main_from_skid;
  issue_entry_t in_entry;
  issue_entry_t main_src;
  issue_entry_t main_q;
  issue_entry_t skid_q;

  always_comb begin
    in_entry.a     = in_a;
    in_entry.b     = in_b;
    in_entry.rs    = in_rs;
    in_entry.rt    = in_rt;
    in_entry.b_imm = in_b_imm;
    in_entry.s     = alu_op_t'(in_s);
    in_entry.sign  = in_sign;
    in_entry.rd    = in_rd;
  end

  // A flush-cycle offer is never accepted.
  assign accept = in_valid && in_ready_q && !flush;
  assign fire   = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = ST_TWO;
        end else if (fire) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low in TWO, so only the promotion can happen here.
        if (fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  assign main_src = main_from_skid ? skid_q : in_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  alu_issue_entry u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (main_load),
    .load_data (main_src),
    .live      (state_q != ST_EMPTY),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .q         (main_q)
  );

  alu_issue_entry u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (skid_load),
    .load_data (in_entry),
    .live      (state_q == ST_TWO),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .q         (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_s     = main_q.s;
  assign out_sign  = main_q.sign;
  assign out_rd    = main_q.rd;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// checked against a queue-based model of the buffered operations.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        imm;
    logic [3:0]  s;
    logic        sign;
    logic [4:0]  rd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_b_imm;
  logic [3:0]  in_s;
  logic        in_sign;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_s;
  logic        out_sign;
  logic [4:0]  out_rd;
  logic [1:0]  dbg_state;

  op_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rs(in_rs), .in_rt(in_rt),
    .in_b_imm(in_b_imm), .in_s(in_s), .in_sign(in_sign), .in_rd(in_rd),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_s(out_s), .out_sign(out_sign),
    .out_rd(out_rd), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stage behaves as an in-order queue of at most two ops: the head is
  // what the ALU sees; every queued op tracks writebacks to its sources.
  logic m_acc, m_fire;
  op_t  m_new, m_tmp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_acc  = in_valid && (exp_q.size() < 2);
      m_fire = (exp_q.size() > 0) && out_ready;
      if (m_fire) void'(exp_q.pop_front());
      if (m_acc) begin
        m_new.a = in_a;   m_new.b = in_b;   m_new.rs = in_rs; m_new.rt = in_rt;
        m_new.imm = in_b_imm; m_new.s = in_s; m_new.sign = in_sign; m_new.rd = in_rd;
        exp_q.push_back(m_new);
      end
      if (wb_en && wb_idx != 5'd0) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          m_tmp = exp_q[i];
          if (m_tmp.rs == wb_idx) m_tmp.a = wb_data;
          if (m_tmp.rt == wb_idx && !m_tmp.imm) m_tmp.b = wb_data;
          exp_q[i] = m_tmp;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_q.size() < 2});
      if (exp_q.size() != 0) begin
        chk("out_a",    out_a, exp_q[0].a);
        chk("out_b",    out_b, exp_q[0].b);
        chk("out_s",    {28'd0, out_s}, {28'd0, exp_q[0].s});
        chk("out_sign", {31'd0, out_sign}, {31'd0, exp_q[0].sign});
        chk("out_rd",   {27'd0, out_rd}, {27'd0, exp_q[0].rd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rs, input logic [4:0] rt, input logic imm,
                      input logic [3:0] s, input logic sign, input logic [4:0] rd);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_rs = rs; in_rt = rt; in_b_imm = imm;
    in_s = s; in_sign = sign; in_rd = rd;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rs = '0; in_rt = '0; in_b_imm = 1'b0;
    in_s = '0; in_sign = 1'b0; in_rd = '0;
    wb_en = 1'b0; wb_idx = '0; wb_data = '0;
    repeat (3) cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_a",     out_a, 32'd0);
    rst_n = 1'b1;
    cyc();

    // streaming: four back-to-back ADDs
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 32'd10, 5'd1, 5'd2, 1'b0, 4'b0010, 1'b0, 5'(i));
    idle(2);

    // stall then drain through the skid entry
    out_ready = 1'b0;
    send(32'd5, 32'd1, 5'd1, 5'd2, 1'b0, 4'b0011, 1'b1, 5'd7);
    send(32'd6, 32'd2, 5'd1, 5'd2, 1'b0, 4'b0100, 1'b0, 5'd8);
    idle(2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_out_a", out_a, 32'd5);
    out_ready = 1'b1;
    idle(3);

    // snoop of A, B untouched
    out_ready = 1'b0;
    send(32'd0, 32'd7, 5'd3, 5'd4, 1'b0, 4'b0010, 1'b0, 5'd9);
    wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'hDEADBEEF;
    idle(1);
    wb_en = 1'b0;
    chk("snoop_a", out_a, 32'hDEADBEEF);
    chk("snoop_b", out_b, 32'd7);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    // immediate B is never refreshed
    send(32'd0, 32'd7, 5'd3, 5'd4, 1'b1, 4'b0010, 1'b0, 5'd9);
    wb_en = 1'b1; wb_idx = 5'd4; wb_data = 32'h12345678;
    idle(1);
    wb_en = 1'b0;
    chk("imm_b", out_b, 32'd7);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // capture bypass
    wb_en = 1'b1; wb_idx = 5'd9; wb_data = 32'h55;
    send(32'd1, 32'd2, 5'd9, 5'd10, 1'b0, 4'b0001, 1'b0, 5'd3);
    wb_en = 1'b0;
    chk("bypass_a", out_a, 32'h55);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    // register 0 never snooped
    send(32'h1234, 32'd2, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 5'd3);
    wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'hFFFF;
    idle(1);
    wb_en = 1'b0;
    chk("r0_a", out_a, 32'h1234);
    out_ready = 1'b1; idle(1); out_ready = 1'b0;

    // flush from TWO with an offer in the same cycle
    send(32'd21, 32'd1, 5'd1, 5'd1, 1'b0, 4'b0010, 1'b0, 5'd1);
    send(32'd22, 32'd1, 5'd1, 5'd1, 1'b0, 4'b0010, 1'b0, 5'd2);
    in_valid = 1'b1; in_a = 32'h77; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    out_ready = 1'b1; idle(2); out_ready = 1'b0;

    // asynchronous reset while in TWO
    send(32'd31, 32'd1, 5'd1, 5'd1, 1'b0, 4'b0010, 1'b0, 5'd1);
    send(32'd32, 32'd1, 5'd1, 5'd1, 1'b0, 4'b0010, 1'b0, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_a",     out_a, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'd41, 32'd3, 5'd2, 5'd3, 1'b0, 4'b0110, 1'b1, 5'd4);
    chk("post_rst_a", out_a, 32'd41);
    idle(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_a = $urandom; in_b = $urandom;
      in_rs = 5'($urandom_range(0, 7)); in_rt = 5'($urandom_range(0, 7));
      in_b_imm = ($urandom_range(0, 3) == 0);
      in_s = 4'($urandom_range(0, 8)); in_sign = 1'($urandom_range(0, 1));
      in_rd = 5'($urandom_range(0, 31));
      wb_en = ($urandom_range(0, 9) < 4);
      wb_idx = 5'($urandom_range(0, 7)); wb_data = $urandom;
      cyc();
    end
    flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
